// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator gated by a filtered PLL lock.
// Optional phase realignment on resync is built when CLK_ENABLE_RESYNC_EN is defined.
module clk_enable_gen #(
    parameter int                        NUM_CH   = 4,
    parameter int                        ACC_W    = 16,
    parameter logic [NUM_CH*ACC_W-1:0]   INC_INIT = {16'hFFFF, 16'h8000, 16'h6000, 16'h4000},
    parameter int                        LOCK_CNT = 1024
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              wr,
    input  logic [2:0]        wr_ch,
    input  logic [ACC_W-1:0]  wr_inc,
    input  logic              resync,
    output logic [NUM_CH-1:0] ce,
    output logic              running
);

    localparam int              CNT_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic             lk_m, lk_s;
    logic [CNT_W-1:0] lk_cnt, cnt_nxt;
    logic [ACC_W-1:0] inc [NUM_CH];
    logic [ACC_W-1:0] acc [NUM_CH];
    logic [ACC_W:0]   sum [NUM_CH];
    logic             realign;

`ifdef CLK_ENABLE_RESYNC_EN
    assign realign = resync;
`else
    logic unused_resync;
    assign realign       = 1'b0;
    assign unused_resync = resync;
`endif

    always_comb begin
        cnt_nxt = '0;
        if (lk_s) begin
            if (lk_cnt == CNT_MAX) cnt_nxt = lk_cnt;
            else                   cnt_nxt = lk_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // State follows the next counter value so RUN is entered on the same edge
    // the filter saturates.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_m    <= 1'b0;
            lk_s    <= 1'b0;
            lk_cnt  <= '0;
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            lk_m    <= pll_locked;
            lk_s    <= lk_m;
            lk_cnt  <= cnt_nxt;
            state   <= (cnt_nxt == CNT_MAX) ? RUN : IDLE;
            running <= (state == RUN);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            ce <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
                acc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr && (32'(wr_ch) == i)) inc[i] <= wr_inc;
                if ((state != RUN) || realign) begin
                    acc[i] <= '0;
                    ce[i]  <= 1'b0;
                end else begin
                    acc[i] <= sum[i][ACC_W-1:0];
                    ce[i]  <= sum[i][ACC_W];
                end
            end
        end
    end

endmodule
